// File: rtl/midi_pkg.sv
// Shared types, constants and status-byte decode for the MIDI input front end.
package midi_pkg;

    typedef enum logic [1:0] {
        RxIdle,
        RxStart,
        RxData,
        RxStop
    } rx_state_e;

    typedef enum logic [1:0] {
        PsWaitStatus,
        PsWaitD1,
        PsWaitD2,
        PsSysex
    } ps_state_e;

    localparam logic [7:0] STATUS_SYSEX = 8'hF0;
    localparam logic [7:0] EOX          = 8'hF7;
    localparam logic [7:0] RT_MIN       = 8'hF8;

    // Data bytes that follow a status byte; 0 also covers F0/F4/F5/F7, which the parser
    // separates from F6 itself.
    function automatic logic [1:0] midi_data_len(input logic [7:0] status);
        logic [1:0] len;
        len = 2'd0;
        case (status[7:4])
            4'h8, 4'h9, 4'hA, 4'hB, 4'hE: len = 2'd2;
            4'hC, 4'hD:                   len = 2'd1;
            4'hF: begin
                case (status[3:0])
                    4'h1, 4'h3: len = 2'd1;
                    4'h2:       len = 2'd2;
                    default:    len = 2'd0;
                endcase
            end
            default: len = 2'd0;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/midi_uart_rx.sv
// Synchronised 8N1 receiver: one byte_valid strobe per good byte, framing_err pulse
// when the stop bit samples low.
module midi_uart_rx
    import midi_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 1600,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_serial,
    output logic       o_byte_valid,
    output logic [7:0] o_byte_data,
    output logic       o_framing_err
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_rx;

    rx_state_e        r_state, w_state_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    logic [2:0]       r_bit_idx, w_bit_idx_next;
    logic [7:0]       r_shift, w_shift_next;
    logic             r_byte_valid, w_byte_valid_next;
    logic             r_framing_err, w_framing_err_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_serial};
        end
    end

    assign w_rx = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= RxIdle;
            r_cnt         <= '0;
            r_bit_idx     <= '0;
            r_shift       <= '0;
            r_byte_valid  <= 1'b0;
            r_framing_err <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_cnt         <= w_cnt_next;
            r_bit_idx     <= w_bit_idx_next;
            r_shift       <= w_shift_next;
            r_byte_valid  <= w_byte_valid_next;
            r_framing_err <= w_framing_err_next;
        end
    end

    always_comb begin
        w_state_next       = r_state;
        w_cnt_next         = r_cnt + 1'b1;
        w_bit_idx_next     = r_bit_idx;
        w_shift_next       = r_shift;
        w_byte_valid_next  = 1'b0;
        w_framing_err_next = 1'b0;
        case (r_state)
            RxIdle: begin
                w_cnt_next = '0;
                if (!w_rx) begin
                    w_state_next = RxStart;
                end
            end
            RxStart: begin
                if (r_cnt == HALF_LAST) begin
                    w_cnt_next     = '0;
                    w_bit_idx_next = '0;
                    w_state_next   = w_rx ? RxIdle : RxData;
                end
            end
            RxData: begin
                if (r_cnt == FULL_LAST) begin
                    w_cnt_next     = '0;
                    w_shift_next   = {w_rx, r_shift[7:1]};
                    w_bit_idx_next = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) begin
                        w_state_next = RxStop;
                    end
                end
            end
            RxStop: begin
                // Straight back to idle at the stop-bit centre so a back-to-back start
                // edge is not missed.
                if (r_cnt == FULL_LAST) begin
                    w_cnt_next         = '0;
                    w_state_next       = RxIdle;
                    w_byte_valid_next  = w_rx;
                    w_framing_err_next = !w_rx;
                end
            end
            default: w_state_next = RxIdle;
        endcase
    end

    assign o_byte_valid  = r_byte_valid;
    assign o_byte_data   = r_shift;
    assign o_framing_err = r_framing_err;

endmodule

// File: rtl/midi_rx_msg.sv
// MIDI message assembler: status-driven length, real-time pass-through, valid/ready output.
// Running status is built only when MIDI_RX_RUNNING_STATUS_EN is defined.
module midi_rx_msg
    import midi_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 1600,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       serial,
    output logic       msg_valid,
    input  logic       msg_ready,
    output logic [7:0] msg_status,
    output logic [7:0] msg_data1,
    output logic [7:0] msg_data2,
    output logic [1:0] msg_len,
    output logic       framing_err,
    output logic       overrun_err
);

    logic       w_byte_valid;
    logic [7:0] w_byte;
    logic       w_framing_err;

    midi_uart_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .SYNC_STAGES  (SYNC_STAGES)
    ) u_uart_rx (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_serial      (serial),
        .o_byte_valid  (w_byte_valid),
        .o_byte_data   (w_byte),
        .o_framing_err (w_framing_err)
    );

    ps_state_e  r_ps, w_ps_next;
    logic [7:0] r_status, w_status_next;
    logic [7:0] r_d1, w_d1_next;
    logic [7:0] w_run_status;
    logic [7:0] w_cur_status;

    logic       w_emit;
    logic [7:0] w_emit_status, w_emit_d1, w_emit_d2;
    logic [1:0] w_emit_len;

    logic       r_msg_valid;
    logic [7:0] r_msg_status, r_msg_d1, r_msg_d2;
    logic [1:0] r_msg_len;
    logic       r_overrun;

`ifdef MIDI_RX_RUNNING_STATUS_EN
    logic [7:0] r_run_status;

    // Channel status is kept; any F0-F7 or a framing error forgets it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run_status <= '0;
        end else if (w_framing_err) begin
            r_run_status <= '0;
        end else if (w_byte_valid && w_byte[7] && (w_byte < RT_MIN)) begin
            r_run_status <= (w_byte < STATUS_SYSEX) ? w_byte : 8'h00;
        end
    end

    assign w_run_status = r_run_status;
`else
    assign w_run_status = 8'h00;
`endif

    // A data byte in WAIT_STATUS starts a message only with a retained status (bit 7 set).
    assign w_cur_status = (r_ps == PsWaitStatus) ? w_run_status : r_status;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ps     <= PsWaitStatus;
            r_status <= '0;
            r_d1     <= '0;
        end else begin
            r_ps     <= w_ps_next;
            r_status <= w_status_next;
            r_d1     <= w_d1_next;
        end
    end

    always_comb begin
        w_ps_next     = r_ps;
        w_status_next = r_status;
        w_d1_next     = r_d1;
        w_emit        = 1'b0;
        w_emit_status = '0;
        w_emit_d1     = '0;
        w_emit_d2     = '0;
        w_emit_len    = 2'd0;
        if (w_framing_err) begin
            w_ps_next = PsWaitStatus;
        end else if (w_byte_valid) begin
            if (w_byte >= RT_MIN) begin
                w_emit        = 1'b1;
                w_emit_status = w_byte;
                w_emit_len    = 2'd1;
            end else if (w_byte[7]) begin
                if (w_byte == STATUS_SYSEX) begin
                    w_ps_next = PsSysex;
                end else if (midi_data_len(w_byte) == 2'd0) begin
                    // F6 is a complete message; EOX, F4 and F5 are simply ignored.
                    w_ps_next = PsWaitStatus;
                    if (w_byte == 8'hF6) begin
                        w_emit        = 1'b1;
                        w_emit_status = w_byte;
                        w_emit_len    = 2'd1;
                    end
                end else begin
                    w_status_next = w_byte;
                    w_ps_next     = PsWaitD1;
                end
            end else begin
                case (r_ps)
                    PsWaitD2: begin
                        w_emit        = 1'b1;
                        w_emit_status = r_status;
                        w_emit_d1     = r_d1;
                        w_emit_d2     = w_byte;
                        w_emit_len    = 2'd3;
                        w_ps_next     = PsWaitStatus;
                    end
                    PsWaitD1, PsWaitStatus: begin
                        if (w_cur_status[7]) begin
                            if (midi_data_len(w_cur_status) == 2'd1) begin
                                w_emit        = 1'b1;
                                w_emit_status = w_cur_status;
                                w_emit_d1     = w_byte;
                                w_emit_len    = 2'd2;
                                w_ps_next     = PsWaitStatus;
                            end else begin
                                w_status_next = w_cur_status;
                                w_d1_next     = w_byte;
                                w_ps_next     = PsWaitD2;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_msg_valid  <= 1'b0;
            r_msg_status <= '0;
            r_msg_d1     <= '0;
            r_msg_d2     <= '0;
            r_msg_len    <= '0;
            r_overrun    <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (w_emit) begin
                if (!r_msg_valid || msg_ready) begin
                    r_msg_valid  <= 1'b1;
                    r_msg_status <= w_emit_status;
                    r_msg_d1     <= w_emit_d1;
                    r_msg_d2     <= w_emit_d2;
                    r_msg_len    <= w_emit_len;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_msg_valid && msg_ready) begin
                r_msg_valid <= 1'b0;
            end
        end
    end

    assign msg_valid   = r_msg_valid;
    assign msg_status  = r_msg_status;
    assign msg_data1   = r_msg_d1;
    assign msg_data2   = r_msg_d2;
    assign msg_len     = r_msg_len;
    assign framing_err = w_framing_err;
    assign overrun_err = r_overrun;

endmodule

// File: tb/tb_midi_rx_msg.sv
// Self-checking bench for midi_rx_msg: vector table, hand sequences and a random byte stream
// checked against a queue-based message model.
module tb_midi_rx_msg;

    localparam int unsigned CPB  = 16;
    localparam int unsigned SYNC = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       serial = 1'b1;
    logic       msg_ready = 1'b1;
    logic       msg_valid;
    logic [7:0] msg_status, msg_data1, msg_data2;
    logic [1:0] msg_len;
    logic       framing_err, overrun_err;

    always #5 clk = ~clk;

    midi_rx_msg #(
        .CLKS_PER_BIT (CPB),
        .SYNC_STAGES  (SYNC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .serial      (serial),
        .msg_valid   (msg_valid),
        .msg_ready   (msg_ready),
        .msg_status  (msg_status),
        .msg_data1   (msg_data1),
        .msg_data2   (msg_data2),
        .msg_len     (msg_len),
        .framing_err (framing_err),
        .overrun_err (overrun_err)
    );

    typedef logic [25:0] msg_t;

    typedef struct {
        logic [47:0] bytes;
        int          n;
        int          bad_idx;
        int          exp_cnt;
        msg_t        exp0;
        msg_t        exp1;
        int          exp_ferr;
    } vec_t;

    msg_t obs_q[$];
    msg_t model_q[$];
    logic [7:0] m_pend[$];
    logic [7:0] m_run;
    int m_need;
    int m_ferr;
    int ferr_seen, ovr_seen;
    int errors, checks;
    vec_t vecs[10];

    function automatic msg_t mk(input logic [7:0] s, input logic [7:0] d1, input logic [7:0] d2,
                                input logic [1:0] l);
        return {s, d1, d2, l};
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (msg_valid && msg_ready) obs_q.push_back({msg_status, msg_data1, msg_data2, msg_len});
            if (framing_err) ferr_seen++;
            if (overrun_err) ovr_seen++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        serial = 1'b0;
        cycles(CPB);
        for (int i = 0; i < 8; i++) begin
            serial = b[i];
            cycles(CPB);
        end
        serial = stop_ok;
        cycles(CPB);
        serial = 1'b1;
        cycles(stop_ok ? 4 : 2 * CPB);
    endtask

    function automatic int ref_len(input logic [7:0] b);
        if (b inside {[8'h80:8'hBF], [8'hE0:8'hEF]}) return 2;
        if (b inside {[8'hC0:8'hDF]}) return 1;
        if (b == 8'hF1 || b == 8'hF3) return 1;
        if (b == 8'hF2) return 2;
        if (b == 8'hF6) return 0;
        return -1;
    endfunction

    function automatic msg_t obs_at(input int k);
        return (obs_q.size() > k) ? obs_q[k] : 26'h3FFFFFF;
    endfunction

    // Model: collect status + data in a list and emit once the list is as long as the status needs.
    task automatic model_byte(input logic [7:0] b, input bit ok);
        int sz;
        if (!ok) begin
            m_pend.delete();
            m_run = 8'h00;
            m_ferr++;
            return;
        end
        if (b >= 8'hF8) begin
            model_q.push_back(mk(b, 8'h00, 8'h00, 2'd1));
            return;
        end
        if (b[7]) begin
            m_pend.delete();
            m_run  = (b < 8'hF0) ? b : 8'h00;
            m_need = ref_len(b);
            if (m_need == 0) model_q.push_back(mk(b, 8'h00, 8'h00, 2'd1));
            else if (m_need > 0) m_pend.push_back(b);
            return;
        end
        if (m_pend.size() == 0) begin
`ifdef MIDI_RX_RUNNING_STATUS_EN
            if (m_run != 8'h00) begin
                m_pend.push_back(m_run);
                m_need = ref_len(m_run);
            end
`endif
            if (m_pend.size() == 0) return;
        end
        m_pend.push_back(b);
        sz = m_pend.size();
        if (sz == m_need + 1) begin
            model_q.push_back(mk(m_pend[0], (sz > 1) ? m_pend[1] : 8'h00,
                                 (sz > 2) ? m_pend[2] : 8'h00, 2'(sz)));
            m_pend.delete();
        end
    endtask

    task automatic clear_obs();
        obs_q.delete();
        ferr_seen = 0;
        ovr_seen  = 0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        clear_obs();
        cycles(3);
        check("reset.msg_valid", 32'(msg_valid), 0);
        check("reset.msg_status", 32'(msg_status), 0);
        check("reset.msg_data1", 32'(msg_data1), 0);
        check("reset.msg_data2", 32'(msg_data2), 0);
        check("reset.msg_len", 32'(msg_len), 0);
        check("reset.framing_err", 32'(framing_err), 0);
        check("reset.overrun_err", 32'(overrun_err), 0);
        rst_n = 1'b1;
        cycles(5);

        vecs[0] = '{48'h903C64000000, 3, -1, 1, mk(8'h90, 8'h3C, 8'h64, 2'd3), '0, 0};
        vecs[1] = '{48'hC50700000000, 2, -1, 1, mk(8'hC5, 8'h07, 8'h00, 2'd2), '0, 0};
        vecs[2] = '{48'h903CF8640000, 4, -1, 2, mk(8'hF8, 8'h00, 8'h00, 2'd1),
                    mk(8'h90, 8'h3C, 8'h64, 2'd3), 0};
`ifdef MIDI_RX_RUNNING_STATUS_EN
        vecs[3] = '{48'h903C64400000, 5, -1, 2, mk(8'h90, 8'h3C, 8'h64, 2'd3),
                    mk(8'h90, 8'h40, 8'h00, 2'd3), 0};
`else
        vecs[3] = '{48'h903C64400000, 5, -1, 1, mk(8'h90, 8'h3C, 8'h64, 2'd3), '0, 0};
`endif
        vecs[4] = '{48'h903C64000000, 3, 0, 0, '0, '0, 1};
        vecs[5] = '{48'hF01122F833F7, 6, -1, 1, mk(8'hF8, 8'h00, 8'h00, 2'd1), '0, 0};
        vecs[6] = '{48'hF21234000000, 3, -1, 1, mk(8'hF2, 8'h12, 8'h34, 2'd3), '0, 0};
        vecs[7] = '{48'hF60000000000, 1, -1, 1, mk(8'hF6, 8'h00, 8'h00, 2'd1), '0, 0};
        vecs[8] = '{48'hF30500000000, 2, -1, 1, mk(8'hF3, 8'h05, 8'h00, 2'd2), '0, 0};
        vecs[9] = '{48'h3C90B0077F00, 5, -1, 1, mk(8'hB0, 8'h07, 8'h7F, 2'd3), '0, 0};

        for (int i = 0; i < 10; i++) begin
            clear_obs();
            for (int j = 0; j < vecs[i].n; j++) begin
                send_byte(vecs[i].bytes[47-8*j -: 8], j != vecs[i].bad_idx);
            end
            cycles(12);
            check($sformatf("vec%0d.count", i), 32'(obs_q.size()), 32'(vecs[i].exp_cnt));
            if (vecs[i].exp_cnt >= 1) check($sformatf("vec%0d.msg0", i), 32'(obs_at(0)), 32'(vecs[i].exp0));
            if (vecs[i].exp_cnt >= 2) check($sformatf("vec%0d.msg1", i), 32'(obs_at(1)), 32'(vecs[i].exp1));
            check($sformatf("vec%0d.framing", i), 32'(ferr_seen), 32'(vecs[i].exp_ferr));
        end

        // Short low glitch must be rejected and leave the receiver ready for a real byte.
        clear_obs();
        serial = 1'b0;
        cycles(3);
        serial = 1'b1;
        cycles(40);
        check("glitch.no_msg", 32'(obs_q.size()), 0);
        send_byte(8'hF8, 1'b1);
        cycles(12);
        check("glitch.after_count", 32'(obs_q.size()), 1);
        check("glitch.after_msg", 32'(obs_at(0)), 32'(mk(8'hF8, 8'h00, 8'h00, 2'd1)));
        check("glitch.framing", 32'(ferr_seen), 0);

        // Output held while not ready; a second message is dropped with an overrun pulse.
        @(posedge clk);
        #1 msg_ready = 1'b0;
        clear_obs();
        send_byte(8'hF8, 1'b1);
        cycles(8);
        check("hold.valid", 32'(msg_valid), 1);
        check("hold.status", 32'(msg_status), 32'h F8);
        check("hold.len", 32'(msg_len), 1);
        send_byte(8'hFA, 1'b1);
        cycles(8);
        check("overrun.count", 32'(ovr_seen), 1);
        check("overrun.status_held", 32'(msg_status), 32'h F8);
        check("overrun.valid_held", 32'(msg_valid), 1);
        @(posedge clk);
        #1 msg_ready = 1'b1;
        cycles(3);
        check("overrun.accepted", 32'(obs_q.size()), 1);
        check("overrun.accepted_msg", 32'(obs_at(0)), 32'(mk(8'hF8, 8'h00, 8'h00, 2'd1)));
        check("overrun.valid_drop", 32'(msg_valid), 0);

        // Reset part-way through a byte: no message and no framing error afterwards.
        clear_obs();
        serial = 1'b0;
        cycles(4 * CPB);
        rst_n  = 1'b0;
        serial = 1'b1;
        cycles(3);
        check("midreset.valid", 32'(msg_valid), 0);
        rst_n = 1'b1;
        cycles(12 * CPB);
        check("midreset.framing", 32'(ferr_seen), 0);
        check("midreset.no_msg", 32'(obs_q.size()), 0);

        // Random stream against the model, starting from the reset state.
        clear_obs();
        model_q.delete();
        m_pend.delete();
        m_run  = 8'h00;
        m_need = 0;
        m_ferr = 0;
        for (int k = 0; k < 80; k++) begin
            logic [7:0] b;
            bit ok;
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 9: b = 8'($urandom_range(0, 127));
                4, 5, 6:       b = 8'($urandom_range(8'h80, 8'hEF));
                7:             b = 8'($urandom_range(8'hF0, 8'hF7));
                default:       b = 8'($urandom_range(8'hF8, 8'hFF));
            endcase
            ok = ($urandom_range(0, 11) != 0);
            model_byte(b, ok);
            send_byte(b, ok);
        end
        cycles(12);
        check("rand.count", 32'(obs_q.size()), 32'(model_q.size()));
        for (int k = 0; k < model_q.size(); k++) begin
            check($sformatf("rand.msg%0d", k), 32'(obs_at(k)), 32'(model_q[k]));
        end
        check("rand.framing", 32'(ferr_seen), 32'(m_ferr));
        check("rand.overrun", 32'(ovr_seen), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
